midi_msg_parser: RTL and testbench

- Converts the raw MIDI byte stream from the UART receiver into the parallel MIDI command interface consumed by the sound generators (`gen_sine` and others): `midi_rdy`, `midi_cmd`, `midi_ch_sysn`, `midi_data0`, `midi_data1`.
- Implements running status, real-time byte interleaving and SysEx discard.
- Sits between `uart_rx` and the generator/voice fan-out.

---
 rtl/midi_msg_parser_pkg.sv | 47 ++++
 rtl/midi_msg_parser_status_decode.sv | 24 ++
 rtl/midi_msg_parser.sv | 123 ++++++++++++
 tb/tb_midi_msg_parser.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/midi_msg_parser_pkg.sv
// rtl/midi_msg_parser_pkg.sv - MIDI command codes, byte classes, parser states and status lookup
package midi_msg_parser_pkg;

   localparam int MIDI_CMD_SIZE = 4;

   localparam logic [3:0] MIDI_CMD_NONE       = 4'd0;
   localparam logic [3:0] MIDI_CMD_NOTE_OFF   = 4'd1;
   localparam logic [3:0] MIDI_CMD_NOTE_ON    = 4'd2;
   localparam logic [3:0] MIDI_CMD_POLY_AT    = 4'd3;
   localparam logic [3:0] MIDI_CMD_CC         = 4'd4;
   localparam logic [3:0] MIDI_CMD_PROG       = 4'd5;
   localparam logic [3:0] MIDI_CMD_CH_PRESS   = 4'd6;
   localparam logic [3:0] MIDI_CMD_PITCH_BEND = 4'd7;
   localparam logic [3:0] MIDI_CMD_SYS        = 4'd8;

   typedef enum logic [2:0] {CLS_DATA, CLS_CHAN, CLS_SYSEX, CLS_COMMON, CLS_RT} byte_class_t;
   typedef enum logic [1:0] {IDLE, WAIT_D0, WAIT_D1, SYSEX} parse_state_t;

   typedef struct packed {
      logic [3:0] cmd;
      logic [1:0] data_cnt;
   } cmd_info_t;

   // System common data counts: F1/F3 carry one byte, F2 two, the rest none.
   function automatic cmd_info_t status_lookup(input logic [3:0] hi, input logic [3:0] lo);
      cmd_info_t info;
      info = '{cmd: MIDI_CMD_NONE, data_cnt: 2'd0};
      case (hi)
         4'h8: info = '{cmd: MIDI_CMD_NOTE_OFF,   data_cnt: 2'd2};
         4'h9: info = '{cmd: MIDI_CMD_NOTE_ON,    data_cnt: 2'd2};
         4'hA: info = '{cmd: MIDI_CMD_POLY_AT,    data_cnt: 2'd2};
         4'hB: info = '{cmd: MIDI_CMD_CC,         data_cnt: 2'd2};
         4'hC: info = '{cmd: MIDI_CMD_PROG,       data_cnt: 2'd1};
         4'hD: info = '{cmd: MIDI_CMD_CH_PRESS,   data_cnt: 2'd1};
         4'hE: info = '{cmd: MIDI_CMD_PITCH_BEND, data_cnt: 2'd2};
         4'hF: begin
            info.cmd = MIDI_CMD_SYS;
            if (lo == 4'h1 || lo == 4'h3) info.data_cnt = 2'd1;
            else if (lo == 4'h2)          info.data_cnt = 2'd2;
            else                          info.data_cnt = 2'd0;
         end
         default: info = '{cmd: MIDI_CMD_NONE, data_cnt: 2'd0};
      endcase
      return info;
   endfunction

endpackage

// File: rtl/midi_msg_parser_status_decode.sv
// rtl/midi_msg_parser_status_decode.sv - combinational byte classifier: class, command and data count
module midi_status_decode
   import midi_msg_parser_pkg::*;
(
   input  logic [7:0] byte_data,
   output logic [2:0] cls,
   output logic [3:0] cmd,
   output logic [1:0] data_cnt
);

   cmd_info_t info;

   always_comb begin
      info     = status_lookup(byte_data[7:4], byte_data[3:0]);
      cmd      = info.cmd;
      data_cnt = info.data_cnt;
      if (!byte_data[7])                cls = CLS_DATA;
      else if (byte_data[7:4] != 4'hF)  cls = CLS_CHAN;
      else if (byte_data == 8'hF0)      cls = CLS_SYSEX;
      else if (byte_data[3])            cls = CLS_RT;
      else                              cls = CLS_COMMON;
   end

endmodule

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI byte stream to parallel command parser with running status,
// real-time interleaving and SysEx discard
module midi_msg_parser
   import midi_msg_parser_pkg::*;
#(
   parameter bit VEL0_IS_OFF = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     byte_rdy,
   input  logic [7:0]               byte_data,
   output logic                     midi_rdy,
   output logic [MIDI_CMD_SIZE-1:0] midi_cmd,
   output logic [3:0]               midi_ch_sysn,
   output logic [6:0]               midi_data0,
   output logic [6:0]               midi_data1
);

   logic [2:0]   cls_raw;
   logic [3:0]   dec_cmd;
   logic [1:0]   dec_cnt;
   byte_class_t  cls;
   parse_state_t state;
   logic [3:0]   rs_cmd;
   logic [3:0]   rs_ch;
   logic [1:0]   rs_cnt;
   logic         rs_keep;
   logic [6:0]   d0_q;
   logic         vel0_hit;

   midi_status_decode u_decode (
      .byte_data (byte_data),
      .cls       (cls_raw),
      .cmd       (dec_cmd),
      .data_cnt  (dec_cnt)
   );

   assign cls      = byte_class_t'(cls_raw);
   assign vel0_hit = VEL0_IS_OFF && (rs_cmd == MIDI_CMD_NOTE_ON) && (byte_data[6:0] == 7'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rs_cmd       <= MIDI_CMD_NONE;
         rs_ch        <= 4'd0;
         rs_cnt       <= 2'd0;
         rs_keep      <= 1'b0;
         d0_q         <= 7'd0;
         midi_rdy     <= 1'b0;
         midi_cmd     <= MIDI_CMD_NONE;
         midi_ch_sysn <= 4'd0;
         midi_data0   <= 7'd0;
         midi_data1   <= 7'd0;
      end else begin
         midi_rdy <= 1'b0;
         if (byte_rdy) begin
            case (cls)
               // Real-time bytes leave state, running status and data0 untouched.
               CLS_RT: begin
                  midi_rdy     <= 1'b1;
                  midi_cmd     <= MIDI_CMD_SYS;
                  midi_ch_sysn <= byte_data[3:0];
                  midi_data0   <= 7'd0;
                  midi_data1   <= 7'd0;
               end
               CLS_CHAN: begin
                  rs_cmd  <= dec_cmd;
                  rs_ch   <= byte_data[3:0];
                  rs_cnt  <= dec_cnt;
                  rs_keep <= 1'b1;
                  state   <= WAIT_D0;
               end
               CLS_SYSEX: state <= SYSEX;
               CLS_COMMON: begin
                  if (dec_cnt == 2'd0) begin
                     if (byte_data == 8'hF6) begin
                        midi_rdy     <= 1'b1;
                        midi_cmd     <= MIDI_CMD_SYS;
                        midi_ch_sysn <= byte_data[3:0];
                        midi_data0   <= 7'd0;
                        midi_data1   <= 7'd0;
                     end
                     state <= IDLE;
                  end else begin
                     rs_cmd  <= dec_cmd;
                     rs_ch   <= byte_data[3:0];
                     rs_cnt  <= dec_cnt;
                     rs_keep <= 1'b0;
                     state   <= WAIT_D0;
                  end
               end
               default: begin
                  case (state)
                     WAIT_D0: begin
                        if (rs_cnt == 2'd2) begin
                           d0_q  <= byte_data[6:0];
                           state <= WAIT_D1;
                        end else begin
                           midi_rdy     <= 1'b1;
                           midi_cmd     <= rs_cmd;
                           midi_ch_sysn <= rs_ch;
                           midi_data0   <= byte_data[6:0];
                           midi_data1   <= 7'd0;
                           state        <= rs_keep ? WAIT_D0 : IDLE;
                        end
                     end
                     WAIT_D1: begin
                        midi_rdy     <= 1'b1;
                        midi_cmd     <= vel0_hit ? MIDI_CMD_NOTE_OFF : rs_cmd;
                        midi_ch_sysn <= rs_ch;
                        midi_data0   <= d0_q;
                        midi_data1   <= byte_data[6:0];
                        state        <= rs_keep ? WAIT_D0 : IDLE;
                     end
                     default: state <= state;
                  endcase
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - scoreboard bench for midi_msg_parser, VEL0_IS_OFF = 1 and 0 side by side
module tb_midi_msg_parser;

   typedef struct {
      int         cyc;
      logic [3:0] cmd_a;
      logic [3:0] cmd_b;
      logic [3:0] ch;
      logic [6:0] d0;
      logic [6:0] d1;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       byte_rdy = 1'b0;
   logic [7:0] byte_data = 8'h00;

   logic       rdy_a, rdy_b;
   logic [3:0] cmd_a, cmd_b, ch_a, ch_b;
   logic [6:0] d0_a, d0_b, d1_a, d1_b;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t qa[$];
   exp_t qb[$];

   midi_msg_parser #(.VEL0_IS_OFF(1'b1)) dut_a (
      .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .byte_data(byte_data),
      .midi_rdy(rdy_a), .midi_cmd(cmd_a), .midi_ch_sysn(ch_a),
      .midi_data0(d0_a), .midi_data1(d1_a)
   );

   midi_msg_parser #(.VEL0_IS_OFF(1'b0)) dut_b (
      .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .byte_data(byte_data),
      .midi_rdy(rdy_b), .midi_cmd(cmd_b), .midi_ch_sysn(ch_b),
      .midi_data0(d0_b), .midi_data1(d1_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_rdy  = 1'b1;
      byte_data = b;
      @(posedge clk);
      #1;
      byte_rdy  = 1'b0;
   endtask

   // cmd_a is expected from the VEL0_IS_OFF=1 instance, cmd_b from the =0 one.
   task automatic send_exp(input logic [7:0] b, input logic [3:0] ca, input logic [3:0] cb,
                           input logic [3:0] ch, input logic [6:0] d0, input logic [6:0] d1);
      exp_t e;
      send(b);
      e.cyc = cyc; e.cmd_a = ca; e.cmd_b = cb; e.ch = ch; e.d0 = d0; e.d1 = d1;
      qa.push_back(e);
      qb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset && rdy_a) begin
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_pulse_a actual=cmd %0d ch %0d required=no pulse", cmd_a, ch_a);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("pulse_a", {cyc, cmd_a, ch_a, 1'b0, d0_a, 1'b0, d1_a},
                {e.cyc, e.cmd_a, e.ch, 1'b0, e.d0, 1'b0, e.d1});
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && rdy_b) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_pulse_b actual=cmd %0d ch %0d required=no pulse", cmd_b, ch_b);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("pulse_b", {cyc, cmd_b, ch_b, 1'b0, d0_b, 1'b0, d1_b},
                {e.cyc, e.cmd_b, e.ch, 1'b0, e.d0, 1'b0, e.d1});
         end
      end
   end

   initial begin
      idle(3);
      chk("reset_outputs_a", {rdy_a, cmd_a, ch_a, d0_a, d1_a}, 64'd0);
      chk("reset_outputs_b", {rdy_b, cmd_b, ch_b, d0_b, d1_b}, 64'd0);
      reset = 1'b0;
      idle(2);

      // basic note on
      send(8'h90); send(8'h50); send_exp(8'h11, 4'd2, 4'd2, 4'd0, 7'h50, 7'h11);
      idle(2);
      // running status with velocity 0
      send(8'h93); send(8'h40); send_exp(8'h21, 4'd2, 4'd2, 4'd3, 7'h40, 7'h21);
      send(8'h40); send_exp(8'h00, 4'd1, 4'd2, 4'd3, 7'h40, 7'h00);
      idle(2);
      // real-time interleave
      send(8'hB1); send(8'h07); send_exp(8'hF8, 4'd8, 4'd8, 4'd8, 7'h00, 7'h00);
      send_exp(8'h64, 4'd4, 4'd4, 4'd1, 7'h07, 7'h64);
      idle(2);
      // program change, SysEx, trailing orphan
      send(8'hC2); send_exp(8'h05, 4'd5, 4'd5, 4'd2, 7'h05, 7'h00);
      send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h06);
      idle(3);
      // orphan data and abandoned partial
      send(8'h12); send(8'h90); send(8'h50);
      send(8'h80); send(8'h3C); send_exp(8'h00, 4'd1, 4'd1, 4'd0, 7'h3C, 7'h00);
      idle(2);
      // system common with two data bytes, no running status afterwards
      send(8'hF2); send(8'h10); send_exp(8'h20, 4'd8, 4'd8, 4'd2, 7'h10, 7'h20);
      send(8'h30);
      idle(2);
      // pitch bend and tune request
      send(8'hE5); send(8'h01); send_exp(8'h02, 4'd7, 4'd7, 4'd5, 7'h01, 7'h02);
      send_exp(8'hF6, 4'd8, 4'd8, 4'd6, 7'h00, 7'h00);
      idle(2);
      // active sensing between note bytes keeps stored data0
      send(8'h91); send(8'h3C); send_exp(8'hFE, 4'd8, 4'd8, 4'hE, 7'h00, 7'h00);
      send_exp(8'h7F, 4'd2, 4'd2, 4'd1, 7'h3C, 7'h7F);
      idle(2);
      // channel pressure running status
      send(8'hD4); send_exp(8'h10, 4'd6, 4'd6, 4'd4, 7'h10, 7'h00);
      send_exp(8'h20, 4'd6, 4'd6, 4'd4, 7'h20, 7'h00);
      idle(2);

      // reset mid-message
      send(8'h90); send(8'h50);
      reset = 1'b1;
      idle(2);
      chk("midreset_outputs_a", {rdy_a, cmd_a, ch_a, d0_a, d1_a}, 64'd0);
      chk("midreset_outputs_b", {rdy_b, cmd_b, ch_b, d0_b, d1_b}, 64'd0);
      reset = 1'b0;
      idle(1);
      send(8'h22);
      idle(3);
      chk("postreset_outputs_a", {rdy_a, cmd_a, ch_a, d0_a, d1_a}, 64'd0);
      chk("postreset_outputs_b", {rdy_b, cmd_b, ch_b, d0_b, d1_b}, 64'd0);

      chk("queue_a_drained", 64'(qa.size()), 64'd0);
      chk("queue_b_drained", 64'(qb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
